relay_link_tx: RTL and testbench

RELAY_LINK_TX -- requirements
Module: relay_link_tx

---
 rtl/relay_link_tx_pkg.sv | 21 ++
 rtl/relay_tx_fifo.sv | 67 ++++++
 rtl/relay_link_tx.sv | 214 +++++++++++++++++++++
 tb/tb_relay_link_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_link_tx_pkg.sv
// Shared definitions for the relay link: transmit FSM state codes, default
// timing/FIFO parameters and the frame parity helper.
package relay_link_tx_pkg;

  localparam int DEF_CLKS_PER_BIT = 24;
  localparam int DEF_FIFO_DEPTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/relay_tx_fifo.sv
// Byte FIFO for relay_link_tx, first-word-fall-through. A push into a full FIFO
// is accepted only when a pop happens in the same cycle; flush wins over both.
module relay_tx_fifo
  import relay_link_tx_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        wr_en_s;
  logic        rd_en_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Accept/retire decisions for this cycle.
  always_comb begin
    rd_en_s = pop && !empty;
    wr_en_s = push && (!full || rd_en_s);
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/relay_link_tx.sv
// relay_link_tx: assembles the encoded relay bit stream into bytes, queues them
// and sends UART frames (8N1). Defining RELAY_TX_PARITY_EN selects 8E1 frames.
module relay_link_tx
  import relay_link_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic sample_en,
  input  logic encoded_in,
  output logic tx_line,
  output logic busy,
  output logic overflow
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] asm_r;
  logic [2:0] asm_cnt_r;
  logic       push_r;
  logic       overflow_r;

  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_dout_s;

  tx_state_e  state_r;
  tx_state_e  state_nxt_s;
  logic [7:0] baud_r;
  logic [2:0] bit_idx_r;
  logic [2:0] bit_nxt_s;
  logic [7:0] data_r;
  logic       tx_line_r;
  logic       line_nxt_s;
  logic       pop_s;
  logic       baud_wrap_s;
`ifdef RELAY_TX_PARITY_EN
  logic       parity_r;
`endif

  assign tx_line  = tx_line_r;
  assign overflow = overflow_r;
  assign busy     = (state_r != ST_IDLE) || !fifo_empty_s;

  // Byte assembler; the completed byte is pushed one cycle after the 8th sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_r     <= 8'h00;
      asm_cnt_r <= 3'd0;
      push_r    <= 1'b0;
    end else if (flush) begin
      asm_r     <= asm_r;
      asm_cnt_r <= 3'd0;
      push_r    <= 1'b0;
    end else begin
      push_r <= sample_en && (asm_cnt_r == 3'd7);
      if (sample_en) begin
        asm_r     <= {asm_r[6:0], encoded_in};
        asm_cnt_r <= asm_cnt_r + 3'd1;
      end else begin
        asm_r     <= asm_r;
        asm_cnt_r <= asm_cnt_r;
      end
    end
  end

  // Sticky drop flag: a push was refused because the FIFO stayed full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r <= 1'b0;
    end else if (push_r && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  relay_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push_r),
    .pop   (pop_s),
    .din   (asm_r),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Transmit state register, baud timer and frame datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= 8'd0;
      bit_idx_r <= 3'd0;
      data_r    <= 8'h00;
      tx_line_r <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      bit_idx_r <= bit_nxt_s;
      tx_line_r <= line_nxt_s;
      if ((state_r == ST_IDLE) || baud_wrap_s) begin
        baud_r <= 8'd0;
      end else begin
        baud_r <= baud_r + 8'd1;
      end
      if (pop_s) begin
        data_r <= fifo_dout_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

`ifdef RELAY_TX_PARITY_EN
  // Parity of the byte being framed, captured when it leaves the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= even_parity(fifo_dout_s);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Next-state logic; bit position only moves when the baud timer wraps.
  always_comb begin
    baud_wrap_s = (state_r != ST_IDLE) && (baud_r == BAUD_LAST);
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_wrap_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_wrap_s && (bit_idx_r == 3'd7)) begin
`ifdef RELAY_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
`ifdef RELAY_TX_PARITY_EN
        if (baud_wrap_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (baud_wrap_s && !fifo_empty_s) begin
          state_nxt_s = ST_START;
        end else if (baud_wrap_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs: FIFO pop, next data bit index and the line level for the next cycle.
  always_comb begin
    pop_s = !fifo_empty_s &&
            ((state_r == ST_IDLE) || ((state_r == ST_STOP) && baud_wrap_s));
    if (pop_s) begin
      bit_nxt_s = 3'd0;
    end else if ((state_r == ST_DATA) && baud_wrap_s) begin
      bit_nxt_s = bit_idx_r + 3'd1;
    end else begin
      bit_nxt_s = bit_idx_r;
    end
    case (state_nxt_s)
      ST_IDLE:   line_nxt_s = 1'b1;
      ST_START:  line_nxt_s = 1'b0;
      ST_DATA:   line_nxt_s = data_r[bit_nxt_s];
`ifdef RELAY_TX_PARITY_EN
      ST_PARITY: line_nxt_s = parity_r;
`else
      ST_PARITY: line_nxt_s = 1'b1;
`endif
      ST_STOP:   line_nxt_s = 1'b1;
      default:   line_nxt_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_relay_link_tx.sv
// Scoreboard bench for relay_link_tx: a frame-level reference model predicts
// accepted bytes and frame start times; a UART-style monitor decodes tx_line.
module tb_relay_link_tx;

  localparam int CLKS  = 4;
  localparam int DEPTH = 8;
`ifdef RELAY_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CLKS;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic sample_en = 1'b0;
  logic encoded_in = 1'b0;
  logic tx_line, busy, overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  logic [7:0] mq[$];
  frame_t     exp_q[$];
  int         m_cnt = 0;
  logic [7:0] m_acc = 8'h00;
  logic       m_pend = 1'b0;
  logic [7:0] m_pbyte = 8'h00;
  logic       m_tx = 1'b0;
  int         m_start = 0;
  int         m_end = 0;
  logic       m_ovf = 1'b0;
  logic       e_busy = 1'b0;
  logic       e_ovf = 1'b0;

  // monitor state
  logic       d_act = 1'b0;
  int         d_t = 0;
  frame_t     d_exp;
  logic [7:0] d_data = 8'h00;

  relay_link_tx #(
    .CLKS_PER_BIT (CLKS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .sample_en  (sample_en),
    .encoded_in (encoded_in),
    .tx_line    (tx_line),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sample_en  = 1'b1;
      encoded_in = b[i];
      tick();
    end
    sample_en = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || m_tx || mq.size() > 0 || d_act || m_pend) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n >= limit) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp<%0d cycle=%0d", n, limit, cyc);
    end
  endtask

  // Reference model: FIFO of bytes, one frame every FL cycles, a new frame
  // starting the cycle after its byte leaves the FIFO.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        exp_q.delete();
        m_cnt = 0;
        m_pend = 1'b0;
        m_tx = 1'b0;
        m_ovf = 1'b0;
      end else begin
        if (mq.size() > 0 && (!m_tx || cyc == m_end)) begin
          frame_t f;
          f.data  = mq.pop_front();
          f.start = cyc + 1;
          exp_q.push_back(f);
          m_tx = 1'b1;
          m_start = cyc + 1;
          m_end = cyc + FL;
        end else if (m_tx && cyc == m_end) begin
          m_tx = 1'b0;
        end
        if (flush) begin
          mq.delete();
          m_ovf = 1'b0;
          m_cnt = 0;
          m_pend = 1'b0;
        end else begin
          if (m_pend) begin
            if (mq.size() < DEPTH) mq.push_back(m_pbyte);
            else m_ovf = 1'b1;
          end
          m_pend = 1'b0;
          if (sample_en) begin
            m_acc = {m_acc[6:0], encoded_in};
            if (m_cnt == 7) begin
              m_pend = 1'b1;
              m_pbyte = m_acc;
              m_cnt = 0;
            end else begin
              m_cnt++;
            end
          end
        end
      end
      e_busy = m_tx || (mq.size() > 0);
      e_ovf  = m_ovf;
      cyc++;
    end
  end

  // Monitor: flag checks every cycle, frame decode sampled mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        d_act = 1'b0;
      end else begin
        chk("busy", busy, e_busy);
        chk("overflow", overflow, e_ovf);
        if (d_act) begin
          d_t++;
          if (d_t % CLKS == CLKS / 2) begin
            int idx;
            idx = d_t / CLKS;
            if (idx == 0) begin
              chk("start_bit", tx_line, 1'b0);
            end else if (idx <= 8) begin
              d_data[idx-1] = tx_line;
`ifdef RELAY_TX_PARITY_EN
            end else if (idx == 9) begin
              chk("parity_bit", tx_line, ^d_exp.data);
`endif
            end else begin
              chk("stop_bit", tx_line, 1'b1);
              chk("frame_data", d_data, d_exp.data);
              d_act = 1'b0;
            end
          end
        end else if (tx_line == 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame got=start_bit exp=idle cycle=%0d", cyc);
          end else begin
            d_exp = exp_q.pop_front();
            chk("frame_start", cyc, d_exp.start);
          end
          d_act = 1'b1;
          d_t = 0;
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (3) tick();
    chk("rst_tx_line", tx_line, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    tick();

    // single 0xA5 frame
    send_byte(8'hA5);
    drain(200);

    // 24 bytes at one sample every CLKS cycles: contiguous frames, no drop
    for (int b = 0; b < 24; b++) begin
      logic [7:0] v;
      v = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        sample_en  = 1'b1;
        encoded_in = v[i];
        tick();
        sample_en  = 1'b0;
        repeat (CLKS - 1) tick();
      end
    end
    chk("stream_overflow", overflow, 1'b0);
    drain(1000);

    // burst of 12 bytes overruns the FIFO; flush clears it mid-frame
    for (int b = 0; b < 12; b++) send_byte(8'($urandom));
    tick();
    chk("burst_overflow", overflow, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_overflow", overflow, 1'b0);
    chk("flush_busy", busy, 1'b1);
    drain(200);

    // fill the FIFO, then complete a byte exactly in the pop cycle
    guard = 0;
    while (mq.size() < DEPTH && guard < 40) begin
      send_byte(8'($urandom));
      tick();
      guard++;
    end
    guard = 0;
    while (!(m_tx && (m_end - cyc == 8)) && guard < 200) begin
      tick();
      guard++;
    end
    send_byte(8'h5A);
    tick();
    tick();
    chk("full_pop_overflow", overflow, 1'b0);
    drain(1000);

    // reset in the middle of a zero-data frame
    send_byte(8'h00);
    guard = 0;
    while (!(m_tx && cyc == m_start + 3 * CLKS) && guard < 200) begin
      tick();
      guard++;
    end
    reset = 1'b1;
    #1;
    chk("midrst_tx_line", tx_line, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_overflow", overflow, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    send_byte(8'h3C);
    drain(200);

    // random samples, data and occasional flushes
    for (int c = 0; c < 1500; c++) begin
      sample_en  = 1'($urandom_range(0, 1));
      encoded_in = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 99) == 0);
      tick();
    end
    sample_en = 1'b0;
    flush = 1'b0;
    drain(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
